// File: rtl/game_ctrl.sv
// Match controller for the pong ball: scores, serve delay, rally speed ramp.
// Optional rally speed ramp is enabled by defining GAME_CTRL_SPEEDUP_EN.
module game_ctrl #(
  parameter int SCORE_WIDTH      = 4,
  parameter int WIN_SCORE        = 9,
  parameter int SERVE_TICKS      = 2000,
  parameter int SPEED_INIT       = 4,
  parameter int SPEED_MAX        = 15,
  parameter int HITS_PER_SPEEDUP = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   paddle_hit,
  input  logic                   out_left,
  input  logic                   out_right,
  output logic                   ball_reset,
  output logic [3:0]             speed,
  output logic [SCORE_WIDTH-1:0] score_l,
  output logic [SCORE_WIDTH-1:0] score_r,
  output logic                   serving,
  output logic                   game_over,
  output logic                   winner
);

  localparam int SW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
  localparam logic [SW-1:0] SERVE_LOAD = SW'(SERVE_TICKS - 1);
  localparam logic [SCORE_WIDTH-1:0] WIN = SCORE_WIDTH'(WIN_SCORE);

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;

  state_t                 state;
  logic [SW-1:0]          serve_cnt;
  logic [SCORE_WIDTH-1:0] score_l_inc;
  logic [SCORE_WIDTH-1:0] score_r_inc;

  assign score_l_inc = score_l + 1'b1;
  assign score_r_inc = score_r + 1'b1;

`ifdef GAME_CTRL_SPEEDUP_EN
  localparam int HW = (HITS_PER_SPEEDUP > 1) ? $clog2(HITS_PER_SPEEDUP) : 1;
  localparam logic [HW-1:0] HIT_LAST = HW'(HITS_PER_SPEEDUP - 1);

  logic [HW-1:0] hit_cnt;
  logic          hit_prev;
  logic          hit_rise;

  assign hit_rise = paddle_hit && !hit_prev;
`else
  logic unused_paddle_hit;
  assign unused_paddle_hit = paddle_hit;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ball_reset <= 1'b1;
      speed      <= '0;
      score_l    <= '0;
      score_r    <= '0;
      serving    <= 1'b0;
      game_over  <= 1'b0;
      winner     <= 1'b0;
      serve_cnt  <= '0;
`ifdef GAME_CTRL_SPEEDUP_EN
      hit_cnt    <= '0;
      hit_prev   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, OVER: begin
          ball_reset <= 1'b1;
          speed      <= '0;
          if (start) begin
            state     <= SERVE;
            score_l   <= '0;
            score_r   <= '0;
            serve_cnt <= SERVE_LOAD;
            serving   <= 1'b1;
            game_over <= 1'b0;
          end
        end
        SERVE: begin
          if (serve_cnt == '0) begin
            state      <= PLAY;
            ball_reset <= 1'b0;
            speed      <= 4'(SPEED_INIT);
            serving    <= 1'b0;
`ifdef GAME_CTRL_SPEEDUP_EN
            hit_cnt    <= '0;
`endif
          end else begin
            serve_cnt <= serve_cnt - 1'b1;
          end
        end
        PLAY: begin
          if (out_left || out_right) begin
            // Any out event ends the rally; a double out is a void point.
            ball_reset <= 1'b1;
            speed      <= '0;
            serve_cnt  <= SERVE_LOAD;
            state      <= SERVE;
            serving    <= 1'b1;
            if (out_left && !out_right) begin
              score_r <= score_r_inc;
              if (score_r_inc == WIN) begin
                state     <= OVER;
                serving   <= 1'b0;
                game_over <= 1'b1;
                winner    <= 1'b1;
              end
            end else if (out_right && !out_left) begin
              score_l <= score_l_inc;
              if (score_l_inc == WIN) begin
                state     <= OVER;
                serving   <= 1'b0;
                game_over <= 1'b1;
                winner    <= 1'b0;
              end
            end
          end
`ifdef GAME_CTRL_SPEEDUP_EN
          else if (hit_rise) begin
            if (hit_cnt == HIT_LAST) begin
              hit_cnt <= '0;
              if (speed != 4'(SPEED_MAX))
                speed <= speed + 1'b1;
            end else begin
              hit_cnt <= hit_cnt + 1'b1;
            end
          end
`endif
        end
        default: state <= IDLE;
      endcase
`ifdef GAME_CTRL_SPEEDUP_EN
      // Held low outside PLAY so a hit level present on entry counts as an edge.
      hit_prev <= (state == PLAY) ? paddle_hit : 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed test of game_ctrl with a short serve delay and a 3-point match.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, paddle_hit, out_left, out_right;
  logic       ball_reset, serving, game_over, winner;
  logic [3:0] speed, score_l, score_r;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  game_ctrl #(
    .SCORE_WIDTH(4), .WIN_SCORE(3), .SERVE_TICKS(8),
    .SPEED_INIT(4), .SPEED_MAX(15), .HITS_PER_SPEEDUP(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .paddle_hit(paddle_hit),
    .out_left(out_left), .out_right(out_right), .ball_reset(ball_reset),
    .speed(speed), .score_l(score_l), .score_r(score_r), .serving(serving),
    .game_over(game_over), .winner(winner)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hit();
    paddle_hit = 1'b1;
    cyc(2);
    paddle_hit = 1'b0;
    cyc(1);
  endtask

  task automatic wait_play();
    for (int i = 0; i < 20 && ball_reset; i++) @(negedge clk);
    check("serve_timeout", {31'd0, ball_reset}, 32'd0);
    $display("txn wait_play: speed=%0d", speed);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ball_reset"}, {31'd0, ball_reset}, 32'd1);
    check({tag, "_speed"}, {28'd0, speed}, 32'd0);
    check({tag, "_score_l"}, {28'd0, score_l}, 32'd0);
    check({tag, "_score_r"}, {28'd0, score_r}, 32'd0);
    check({tag, "_serving"}, {31'd0, serving}, 32'd0);
    check({tag, "_game_over"}, {31'd0, game_over}, 32'd0);
    check({tag, "_winner"}, {31'd0, winner}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; paddle_hit = 1'b0; out_left = 1'b0; out_right = 1'b0;
    cyc(3);
    check_reset_vals("rst");
    reset = 1'b1;
    cyc(2);
    check("idle_ball_reset", {31'd0, ball_reset}, 32'd1);

    // Start pulse: serve lasts exactly 8 cycles, then rally at speed 4
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("start_score_l", {28'd0, score_l}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("serve_serving", {31'd0, serving}, 32'd1);
      check("serve_ball_reset", {31'd0, ball_reset}, 32'd1);
      cyc(1);
    end
    check("play_serving", {31'd0, serving}, 32'd0);
    check("play_ball_reset", {31'd0, ball_reset}, 32'd0);
    check("play_speed", {28'd0, speed}, 32'd4);
    $display("txn start/serve: serving done, speed=%0d", speed);

    // Speed ramp (or fixed speed in the default build)
`ifdef GAME_CTRL_SPEEDUP_EN
    repeat (4) hit();
    check("speed_after_4", {28'd0, speed}, 32'd5);
    repeat (44) hit();
    check("speed_sat", {28'd0, speed}, 32'd15);
`else
    repeat (4) hit();
    check("speed_fixed_4", {28'd0, speed}, 32'd4);
    repeat (16) hit();
    check("speed_fixed_20", {28'd0, speed}, 32'd4);
`endif
    $display("txn hits: speed=%0d", speed);

    // start ignored during PLAY
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("start_in_play_serving", {31'd0, serving}, 32'd0);
    check("start_in_play_ball_reset", {31'd0, ball_reset}, 32'd0);

    // out_left held for 3 cycles scores once
    out_left = 1'b1;
    cyc(1);
    check("outl_score_r", {28'd0, score_r}, 32'd1);
    check("outl_serving", {31'd0, serving}, 32'd1);
    check("outl_speed", {28'd0, speed}, 32'd0);
    check("outl_ball_reset", {31'd0, ball_reset}, 32'd1);
    cyc(2);
    out_left = 1'b0;
    check("outl_held_score_r", {28'd0, score_r}, 32'd1);
    $display("txn out_left held: score_r=%0d", score_r);

    // Right player takes two more points and wins
    wait_play();
    out_left = 1'b1;
    cyc(1);
    out_left = 1'b0;
    check("pt2_score_r", {28'd0, score_r}, 32'd2);
    check("pt2_game_over", {31'd0, game_over}, 32'd0);
    wait_play();
    out_left = 1'b1;
    cyc(1);
    out_left = 1'b0;
    check("win_score_r", {28'd0, score_r}, 32'd3);
    check("win_game_over", {31'd0, game_over}, 32'd1);
    check("win_winner", {31'd0, winner}, 32'd1);
    check("win_serving", {31'd0, serving}, 32'd0);
    check("win_speed", {28'd0, speed}, 32'd0);
    $display("txn match over: winner=%0d score_r=%0d", winner, score_r);

    // Out events in OVER are ignored
    out_right = 1'b1;
    cyc(2);
    out_right = 1'b0;
    check("over_score_l", {28'd0, score_l}, 32'd0);
    check("over_frozen_r", {28'd0, score_r}, 32'd3);

    // Restart from OVER
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("restart_score_r", {28'd0, score_r}, 32'd0);
    check("restart_serving", {31'd0, serving}, 32'd1);
    check("restart_game_over", {31'd0, game_over}, 32'd0);

    // Double out: void point
    wait_play();
    out_left = 1'b1; out_right = 1'b1;
    cyc(1);
    out_left = 1'b0; out_right = 1'b0;
    check("void_score_l", {28'd0, score_l}, 32'd0);
    check("void_score_r", {28'd0, score_r}, 32'd0);
    check("void_serving", {31'd0, serving}, 32'd1);
    $display("txn void point: score_l=%0d score_r=%0d", score_l, score_r);

    // Hit together with out_right: out wins
    wait_play();
    paddle_hit = 1'b1; out_right = 1'b1;
    cyc(1);
    paddle_hit = 1'b0; out_right = 1'b0;
    check("hitout_score_l", {28'd0, score_l}, 32'd1);
    check("hitout_score_r", {28'd0, score_r}, 32'd0);
    check("hitout_speed", {28'd0, speed}, 32'd0);
    wait_play();
    check("hitout_next_speed", {28'd0, speed}, 32'd4);
    $display("txn hit+out_right: score_l=%0d", score_l);

    // Reset mid-SERVE
    out_right = 1'b1;
    cyc(1);
    out_right = 1'b0;
    check("pre_rst_score_l", {28'd0, score_l}, 32'd2);
    cyc(2);
    reset = 1'b0;
    #1;
    check_reset_vals("rst_serve");
    cyc(1);
    reset = 1'b1;
    $display("txn reset mid-serve");

    // Reset mid-PLAY
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_play();
    cyc(2);
    reset = 1'b0;
    #1;
    check_reset_vals("rst_play");
    cyc(1);
    reset = 1'b1;
    cyc(2);
    check("post_rst_idle", {31'd0, serving}, 32'd0);
    $display("txn reset mid-play");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Match-level controller sitting directly downstream of `ball`, and feeding its control inputs back to it. It consumes the ball's `paddle_hit`, `out_left` and `out_right` events and keeps both players' scores. It drives `ball_reset` and `speed` back into `ball`, sequencing each match through idle, serve delay, rally and game-over, and ramping ball speed as a rally lengthens.

## Interface
Parameters:
- `SCORE_WIDTH`, 4: width of each score counter.
- `WIN_SCORE`, 9: score that ends the match; must be ≤ 2^SCORE_WIDTH−1.
- `SERVE_TICKS`, 2000: cycles the ball is held centred before each serve (1 s at 2 kHz).
- `SPEED_INIT`, 4: speed at start of each rally.
- `SPEED_MAX`, 15: speed ceiling.
- `HITS_PER_SPEEDUP`, 4: paddle hits per +1 speed step.

Ports:
- `clk` in 1: game clock (same clock as `ball`).
- `reset` in 1: asynchronous, active-low; `reset`=0 resets the block.
- `start` in 1: start / restart request, level-sampled.
- `paddle_hit` in 1: from `ball`.
- `out_left` in 1: from `ball`; left player missed.
- `out_right` in 1: from `ball`; right player missed.
- `ball_reset` out 1: to `ball`; holds the ball centred and re-randomises its direction.
- `speed` out 4: to `ball`.
- `score_l` out SCORE_WIDTH: left player score.
- `score_r` out SCORE_WIDTH: right player score.
- `serving` out 1: high in SERVE.
- `game_over` out 1: high in OVER.
- `winner` out 1: 0 = left won, 1 = right won; valid while `game_over`=1.

## Operation
- States: IDLE, SERVE, PLAY, OVER. All outputs are registered.
- Reset values:
  - state IDLE, `ball_reset`=1, `speed`=0, `score_l`=`score_r`=0;
  - `serving`=0, `game_over`=0, `winner`=0;
  - serve counter 0, hit counter 0, `paddle_hit` edge register 0.
- IDLE:
  - `ball_reset`=1, `speed`=0.
  - `start`=1 → SERVE; clear both scores; load serve counter with SERVE_TICKS−1.
- SERVE:
  - `ball_reset`=1, `speed`=0, `serving`=1. The serve counter decrements each cycle.
  - When the counter is at 0 → PLAY, `speed`=SPEED_INIT, hit counter cleared.
- PLAY:
  - `ball_reset`=0.
  - Paddle hits are counted on the rising edge of `paddle_hit` only; a level held for several cycles is one hit.
  - When the hit counter reaches HITS_PER_SPEEDUP−1 and another hit arrives, the counter returns to 0 and `speed` increments, saturating at SPEED_MAX.
  - `out_left`=1 → `score_r`+1. `out_right`=1 → `score_l`+1.
  - If the incremented score equals WIN_SCORE → OVER, with `winner` set to the scoring side. Otherwise → SERVE with the serve counter reloaded.
- OVER:
  - `ball_reset`=1, `speed`=0, `game_over`=1; scores and `winner` are frozen.
  - `start`=1 → SERVE with scores cleared and `game_over`=0.
- Boundary conditions:
  - `start` is ignored in SERVE and PLAY.
  - `out_left` and `out_right` together in PLAY: void point; no score change; → SERVE.
  - `paddle_hit` rising in the same cycle as any out event: the out event wins and the hit is not counted.
  - Out events outside PLAY are ignored. Because `out_*` stays asserted until `ball_reset` takes effect, each miss scores exactly once.
  - Scores never wrap: WIN_SCORE ends the match first.
  - Reset asserted mid-operation: returns immediately (asynchronously) to the reset values.

## Timing
- Out event sampled at edge N: at N+1 the score is updated, state is SERVE/OVER, `ball_reset`=1 and `speed`=0.
- SERVE lasts exactly SERVE_TICKS cycles (`ball_reset` high for SERVE_TICKS cycles), then `ball_reset`=0 and `speed`=SPEED_INIT on the same edge.
- `start` sampled at edge N in IDLE/OVER: `serving`=1 and scores are 0 at N+1.
- Speed step: the qualifying `paddle_hit` rising edge sampled at N gives the new `speed` at N+1.
- The `paddle_hit` edge register is cleared on entry to PLAY, so a hit level already present on entry counts as a rising edge.

## Configuration
- `GAME_CTRL_SPEEDUP_EN` defined:
  - hit counter and edge detector are present;
  - speed ramps as described.
- `GAME_CTRL_SPEEDUP_EN` undefined:
  - hit counter and edge detector are removed;
  - `speed` is SPEED_INIT throughout PLAY and `paddle_hit` is unused.
- Score, serve and state behaviour is identical in both builds.

## Test plan
All scenarios use SERVE_TICKS=8, HITS_PER_SPEEDUP=4, SPEED_INIT=4 and WIN_SCORE=3.

- Reset release, then `start` pulse → `serving` for exactly 8 cycles with `ball_reset`=1, then `ball_reset`=0 and `speed`=4.
- In PLAY, `paddle_hit` high for 2 cycles, repeated as 4 separate hits → `speed`=5; 44 further hits → `speed` saturates at 15.
- `out_left` held for 3 cycles in PLAY → `score_r`=1 (not 3), state SERVE, `speed`=0.
- Right player wins 3 points → `game_over`=1, `winner`=1, `score_r`=3; `start` → scores 0, `serving`=1.
- `out_left` and `out_right` together, and `paddle_hit` rising together with `out_right` → no score in the first case, `score_l`+1 only in the second, and no speed change.
- `reset` driven 0 mid-SERVE and mid-PLAY → all outputs at reset values immediately; build without `GAME_CTRL_SPEEDUP_EN` → `speed` stays at 4 through 20 hits.
